// File: rtl/mult_arb_pkg.sv
// Shared widths, FSM encoding and counter sizing for the multiplier arbiter.
// Optional signed operand handling is selected by MULT_ARB_SIGNED_EN.
package mult_arb_pkg;
  localparam int OPW = 18;
  localparam int PW  = 36;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_e;

  function automatic int cnt_w(input int lat);
    return ($clog2(lat) < 1) ? 1 : $clog2(lat);
  endfunction
endpackage

// File: rtl/mult_arb_rr.sv
// Combinational round-robin picker.
// Returns the first set request at or after the pointer, wrapping.
module mult_arb_rr #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);
  logic found;
  int   j;

  always_comb begin
    valid = |req;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        idx   = IW'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NREQ requesters.
// MULT_ARB_SIGNED_EN: two's complement operands via magnitude + sign fixup.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*OPW-1:0] a_in,
  input  logic [NREQ*OPW-1:0] b_in,
  output logic [NREQ-1:0]   ack,
  output logic [PW-1:0]     result,
  output logic              busy,
  output logic [OPW-1:0]    mul_a,
  output logic [OPW-1:0]    mul_b,
  input  logic [PW-1:0]     mul_p
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = cnt_w(MUL_LAT);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OPW-1:0]  mul_a_q, mul_a_d;
  logic [OPW-1:0]  mul_b_q, mul_b_d;
  logic [PW-1:0]   result_q, result_d;

  logic            rr_valid;
  logic [IW-1:0]   rr_idx;
  logic [OPW-1:0]  a_sel, b_sel;
  logic [OPW-1:0]  a_op, b_op;
  logic [PW-1:0]   p_fix;

  mult_arb_rr #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

  assign a_sel = a_in[rr_idx*OPW +: OPW];
  assign b_sel = b_in[rr_idx*OPW +: OPW];

`ifdef MULT_ARB_SIGNED_EN
  logic sign_q, sign_d;

  // The multiplier is unsigned: feed magnitudes, restore the sign on capture.
  assign a_op  = a_sel[OPW-1] ? (~a_sel + OPW'(1)) : a_sel;
  assign b_op  = b_sel[OPW-1] ? (~b_sel + OPW'(1)) : b_sel;
  assign p_fix = sign_q ? (~mul_p + PW'(1)) : mul_p;

  always_comb begin
    sign_d = sign_q;
    if (state_q == IDLE && rr_valid)
      sign_d = a_sel[OPW-1] ^ b_sel[OPW-1];
  end

  always_ff @(posedge clk) begin
    if (reset) sign_q <= 1'b0;
    else       sign_q <= sign_d;
  end
`else
  assign a_op  = a_sel;
  assign b_op  = b_sel;
  assign p_fix = mul_p;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (rr_valid) begin
          gnt_d   = rr_idx;
          mul_a_d = a_op;
          mul_b_d = b_op;
          cnt_d   = CW'(MUL_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          result_d = p_fix;
          state_d  = ACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACK: begin
        ptr_d   = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + IW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gnt_q    <= '0;
      cnt_q    <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ACK) ack[gnt_q] = 1'b1;
  end

  assign busy   = (state_q != IDLE);
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;
  assign result = result_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a settling multiplier model.
// Honours MULT_ARB_SIGNED_EN for the reference products.
module tb_mult_arbiter;
  localparam int N   = 4;
  localparam int LAT = 20;
  localparam int OW  = 18;
  localparam int PW  = 36;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*OW-1:0] a_in, b_in;
  logic [N-1:0]    ack;
  logic [PW-1:0]   result;
  logic            busy;
  logic [OW-1:0]   mul_a, mul_b;
  logic [PW-1:0]   mul_p;

  always #5 clk = ~clk;

  mult_arbiter #(
    .NREQ    (N),
    .MUL_LAT (LAT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .ack    (ack),
    .result (result),
    .busy   (busy),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .mul_p  (mul_p)
  );

  // Shift-add multiplier stand-in: product only valid after 19 stable cycles.
  logic [OW-1:0] pa, pb;
  int            stab = 0;
  logic [PW-1:0] full_p;
  assign full_p = {18'b0, mul_a} * {18'b0, mul_b};
  assign mul_p  = (stab >= 19) ? full_p : ~full_p;

  always @(negedge clk) begin
    if (mul_a !== pa || mul_b !== pb) begin
      pa   <= mul_a;
      pb   <= mul_b;
      stab <= 0;
    end else if (stab < 1000) begin
      stab <= stab + 1;
    end
  end

  // Requester side
  logic [N-1:0]  rq;
  logic [OW-1:0] opa [N];
  logic [OW-1:0] opb [N];
  bit            hold [N];
  int            order [$];
  logic [PW-1:0] res_q [$];

  // Reference model state
  int            cyc = 0;
  int            ptr_m = 0;
  int            next_free = 0;
  bit            job_on = 0;
  int            job_g, job_t;
  logic [PW-1:0] job_p;
  logic [OW-1:0] job_a, job_b;
  logic [PW-1:0] exp_res = '0;
  logic [N-1:0]  exp_ack;
  logic          exp_busy;

  int errs = 0;
  int checks = 0;

  function automatic logic [PW-1:0] prod(input logic [OW-1:0] a,
                                         input logic [OW-1:0] b);
`ifdef MULT_ARB_SIGNED_EN
    logic signed [PW-1:0] sa, sb;
    sa = {{18{a[17]}}, a};
    sb = {{18{b[17]}}, b};
    return PW'(sa * sb);
`else
    return {18'b0, a} * {18'b0, b};
`endif
  endfunction

  function automatic logic [OW-1:0] opnd(input logic [OW-1:0] v);
`ifdef MULT_ARB_SIGNED_EN
    return v[OW-1] ? OW'(-v) : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [PW-1:0] got,
                     input logic [PW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive();
    req = rq;
    for (int i = 0; i < N; i++) begin
      a_in[i*OW +: OW] = opa[i];
      b_in[i*OW +: OW] = opb[i];
    end
  endtask

  task automatic step();
    int g;
    drive();
    @(posedge clk);
    cyc++;
    exp_ack = '0;
    if (job_on && cyc == job_t + LAT) begin
      exp_ack[job_g] = 1'b1;
      exp_res = job_p;
      ptr_m   = (job_g + 1) % N;
      job_on  = 0;
    end else if (!job_on && cyc >= next_free && rq != '0) begin
      g = ptr_m;
      while (!rq[g]) g = (g + 1) % N;
      job_on    = 1;
      job_g     = g;
      job_t     = cyc;
      job_p     = prod(opa[g], opb[g]);
      job_a     = opnd(opa[g]);
      job_b     = opnd(opb[g]);
      next_free = cyc + LAT + 2;
    end
    exp_busy = job_on || (exp_ack != '0);
    #1;
    chk("ack", PW'(ack), PW'(exp_ack));
    chk("result", result, exp_res);
    chk("busy", PW'(busy), PW'(exp_busy));
    if (job_on) begin
      chk("mul_a", PW'(mul_a), PW'(job_a));
      chk("mul_b", PW'(mul_b), PW'(job_b));
    end
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        order.push_back(i);
        res_q.push_back(result);
        if (!hold[i]) rq[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    rq    = '0;
    for (int k = 0; k < n; k++) begin
      drive();
      @(posedge clk);
      cyc++;
      job_on    = 0;
      ptr_m     = 0;
      exp_res   = '0;
      next_free = cyc + 1;
      #1;
      chk("rst_ack", PW'(ack), '0);
      chk("rst_result", result, '0);
      chk("rst_busy", PW'(busy), '0);
      chk("rst_mul_a", PW'(mul_a), '0);
      chk("rst_mul_b", PW'(mul_b), '0);
    end
    reset = 1'b0;
  endtask

  task automatic run_ack(input int i, input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!ack[i] && n < max);
    chk($sformatf("ack%0d_seen", i), PW'(ack[i]), PW'(1));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    rq = '0;
    for (int i = 0; i < N; i++) begin
      opa[i] = '0;
      opb[i] = '0;
      hold[i] = 0;
    end
    drive();
    do_reset(2);

    // Single job: latency counted in edges from the cycle req rises
    opa[0] = 18'd3; opb[0] = 18'd5; rq[0] = 1'b1;
    run_ack(0, 60, n);
    chk("lat0", PW'(n), PW'(LAT + 1));
    chk("res_3x5", result, 36'h00000000F);
    repeat (3) step();

    // Max operands, held request regranted with identical operands
    opa[2] = 18'h3FFFF; opb[2] = 18'h3FFFF; rq[2] = 1'b1; hold[2] = 1;
    run_ack(2, 60, n);
`ifdef MULT_ARB_SIGNED_EN
    chk("res_max", result, 36'h000000001);
`else
    chk("res_max", result, 36'hFFFF80001);
`endif
    hold[2] = 0;
    run_ack(2, 60, n);
    chk("regrant_gap", PW'(n), PW'(LAT + 2));
`ifdef MULT_ARB_SIGNED_EN
    chk("res_regrant", result, 36'h000000001);
`else
    chk("res_regrant", result, 36'hFFFF80001);
`endif

    // All four from reset: strict round-robin order
    do_reset(1);
    for (int i = 0; i < N; i++) begin
      opa[i] = OW'(i + 1);
      opb[i] = 18'd10;
    end
    rq = '1;
    order.delete();
    res_q.delete();
    n = 0;
    while (order.size() < 4 && n < 200) begin
      step();
      n++;
    end
    chk("rr_cnt", PW'(order.size()), PW'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < order.size()) begin
        chk($sformatf("rr_ord%0d", k), PW'(order[k]), PW'(k));
        chk($sformatf("rr_res%0d", k), res_q[k], PW'(10 * (k + 1)));
      end
    end

    // Move pointer to 2, then 0 and 3 compete: 3 first
    opa[1] = 18'd2; opb[1] = 18'd2; rq[1] = 1'b1;
    run_ack(1, 60, n);
    order.delete();
    opa[0] = 18'd6; opb[0] = 18'd7; rq[0] = 1'b1;
    opa[3] = 18'd8; opb[3] = 18'd9; rq[3] = 1'b1;
    n = 0;
    while (order.size() < 2 && n < 100) begin
      step();
      n++;
    end
    chk("ptr_cnt", PW'(order.size()), PW'(2));
    if (order.size() == 2) begin
      chk("ptr_first", PW'(order[0]), PW'(3));
      chk("ptr_second", PW'(order[1]), PW'(0));
    end

    // Request dropped and operands changed during WAIT
    opa[1] = 18'd7; opb[1] = 18'd9; rq[1] = 1'b1;
    repeat (3) step();
    rq[1] = 1'b0;
    opa[1] = OW'($urandom);
    opb[1] = OW'($urandom);
    run_ack(1, 60, n);
    chk("res_drop", result, 36'd63);

    // Reset in the middle of WAIT aborts the job
    repeat (2) step();
    opa[2] = 18'd100; opb[2] = 18'd100; rq[2] = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      step();
      n++;
    end
    repeat (5) step();
    do_reset(1);
    opa[0] = 18'd11; opb[0] = 18'd13; rq[0] = 1'b1;
    rq[2] = 1'b0;
    run_ack(0, 60, n);
    chk("res_after_rst", result, 36'd143);

`ifdef MULT_ARB_SIGNED_EN
    opa[1] = 18'h3FFFD; opb[1] = 18'd5; rq[1] = 1'b1;
    run_ack(1, 60, n);
    chk("s_neg3x5", result, 36'hFFFFFFFF1);
    opa[3] = 18'h20000; opb[3] = 18'h20000; rq[3] = 1'b1;
    run_ack(3, 60, n);
    chk("s_min_sq", result, 36'h400000000);
`endif

    // Randomised traffic against the model
    for (int c = 0; c < 700; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rq[i] && $urandom_range(7) == 0) begin
          opa[i] = OW'($urandom);
          opb[i] = OW'($urandom);
          rq[i]  = 1'b1;
        end
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
